seg14_scroll_scan: RTL and testbench

- Drives the 12-digit, 14-segment multiplexed display from a writable character buffer.
- Replaces the hard-wired message scanner; it is the producer side that feeds the digit-select and segment lines.
- Divides the system clock into digit scan slots and fetches 6-bit character codes from a double-banked 16-entry message buffer.
- Encodes each character to 14 segments and optionally scrolls messages longer than 12 characters.

---
 rtl/seg14_pkg.sv | 51 +++++
 rtl/seg14_font.sv | 17 +
 rtl/seg14_scroll_scan.sv | 170 +++++++++++++++++
 tb/tb_seg14_scroll_scan.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared constants and the 14-segment font for the scrolling display scanner.
// Segment bit order, MSB first: a b c d e f g1 g2 h i j k l m (h/j/k/m diagonals, i/l centre verticals).
package seg14_pkg;

    localparam int CHAR_SPACE = 36;
    localparam int NUM_DIGITS = 12;
    localparam int FONT_CODES = 37;

    typedef logic [13:0] seg_t;

    localparam seg_t FONT [FONT_CODES] = '{
        14'b11111100001001,  // 0
        14'b01100000001000,  // 1
        14'b11011011000000,  // 2
        14'b11110001000000,  // 3
        14'b01100111000000,  // 4
        14'b10110111000000,  // 5
        14'b10111111000000,  // 6
        14'b11100000000000,  // 7
        14'b11111111000000,  // 8
        14'b11110111000000,  // 9
        14'b11101111000000,  // A
        14'b11110001010010,  // B
        14'b10011100000000,  // C
        14'b11110000010010,  // D
        14'b10011110000000,  // E
        14'b10001110000000,  // F
        14'b10111101000000,  // G
        14'b01101111000000,  // H
        14'b10010000010010,  // I
        14'b01111000000000,  // J
        14'b00001110001100,  // K
        14'b00011100000000,  // L
        14'b01101100101000,  // M
        14'b01101100100100,  // N
        14'b11111100000000,  // O
        14'b11001111000000,  // P
        14'b11111100000100,  // Q
        14'b11001111000100,  // R
        14'b10110111000000,  // S
        14'b10000000010010,  // T
        14'b01111100000000,  // U
        14'b00001100001001,  // V
        14'b01101100000101,  // W
        14'b00000000101101,  // X
        14'b00000000101010,  // Y
        14'b10010000001001,  // Z
        14'b00000000000000   // space
    };

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment encoder; codes outside the font are blank.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [5:0]  code_i,
    output logic [13:0] seg_o
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        seg_o = '0;
        if (code_i < 6'(FONT_CODES)) begin
            seg_o = FONT[code_i];
        end
    end

endmodule

// File: rtl/seg14_scroll_scan.sv
// Multiplexed 12-digit 14-segment scanner fed from a double-banked message buffer,
// with optional scrolling of messages longer than the display.
module seg14_scroll_scan
    import seg14_pkg::*;
#(
    parameter int CLK_DIV       = 1000,
    parameter int SCROLL_FRAMES = 50,
    parameter int MSG_MAX       = 16
) (
`ifdef USE_POWER_PINS
    inout  wire         vdd,
    inout  wire         vss,
`endif
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [5:0]  wr_char,
    input  logic        commit,
    input  logic [4:0]  commit_len,
    input  logic        scroll_en,
    output logic [11:0] sel,
    output logic [13:0] segm,
    output logic        frame_end
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [3:0]    PTR_LAST   = 4'(NUM_DIGITS - 1);
    localparam logic [4:0]    LEN_MAX    = 5'(MSG_MAX);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [3:0]    offset_q, offset_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]    active_len_q, active_len_d;
    logic [4:0]    len_pend_q, len_pend_d;
    logic          pending_q, pending_d;
    logic          bank_sel_q, bank_sel_d;
    logic [11:0]   sel_q, sel_d;
    logic [13:0]   segm_q, segm_d;
    logic          frame_end_q, frame_end_d;

    logic [5:0]    bank_q [2][MSG_MAX];

    logic          tick, frame_tick, scrolling, blank;
    logic          wr_fire, commit_fire;
    logic [4:0]    idx_sum, idx_wrap;
    logic [3:0]    idx, offset_inc;
    logic [4:0]    len_clamped;
    logic [5:0]    cur_char;
    logic [13:0]   font_seg;

    assign tick        = (prescaler_q == PRESC_LAST);
    assign frame_tick  = tick && (ptr_q == PTR_LAST);
    assign scrolling   = scroll_en && (active_len_q > 5'(NUM_DIGITS));
    assign wr_fire     = wr_valid && !pending_q;
    assign commit_fire = commit && !pending_q;
    assign len_clamped = (commit_len > LEN_MAX) ? LEN_MAX : commit_len;

    // offset < active_len and ptr <= 11 keep the sum below 2*active_len, so one subtract wraps it.
    assign idx_sum    = 5'(offset_q) + 5'(ptr_q);
    assign idx_wrap   = (idx_sum >= active_len_q) ? idx_sum - active_len_q : idx_sum;
    assign idx        = scrolling ? 4'(idx_wrap) : ptr_q;
    assign blank      = !scrolling && (5'(ptr_q) >= active_len_q);
    assign offset_inc = (5'(offset_q) + 5'd1 == active_len_q) ? 4'd0 : offset_q + 4'd1;
    assign cur_char   = bank_q[bank_sel_q][idx];

    seg14_font u_font (
        .code_i (cur_char),
        .seg_o  (font_seg)
    );

    always_comb begin
        prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
        ptr_d        = ptr_q;
        offset_d     = offset_q;
        frame_cnt_d  = frame_cnt_q;
        active_len_d = active_len_q;
        len_pend_d   = len_pend_q;
        pending_d    = pending_q;
        bank_sel_d   = bank_sel_q;
        sel_d        = sel_q;
        segm_d       = segm_q;
        frame_end_d  = frame_tick;

        if (tick) begin
            ptr_d  = (ptr_q == PTR_LAST) ? 4'd0 : ptr_q + 4'd1;
            sel_d  = 12'(1) << ptr_q;
            segm_d = blank ? '0 : font_seg;
        end

        // Bank swap and scroll advance both happen only at the frame boundary.
        if (frame_tick) begin
            if (pending_q) begin
                bank_sel_d   = ~bank_sel_q;
                active_len_d = len_pend_q;
                offset_d     = '0;
                frame_cnt_d  = '0;
                pending_d    = 1'b0;
            end else if (scrolling) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d = '0;
                    offset_d    = offset_inc;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end else begin
                offset_d    = '0;
                frame_cnt_d = '0;
            end
        end

        if (commit_fire) begin
            pending_d  = 1'b1;
            len_pend_d = len_clamped;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q  <= '0;
            ptr_q        <= '0;
            offset_q     <= '0;
            frame_cnt_q  <= '0;
            active_len_q <= '0;
            len_pend_q   <= '0;
            pending_q    <= 1'b0;
            bank_sel_q   <= 1'b0;
            sel_q        <= '0;
            segm_q       <= '0;
            frame_end_q  <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            ptr_q        <= ptr_d;
            offset_q     <= offset_d;
            frame_cnt_q  <= frame_cnt_d;
            active_len_q <= active_len_d;
            len_pend_q   <= len_pend_d;
            pending_q    <= pending_d;
            bank_sel_q   <= bank_sel_d;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_end_q  <= frame_end_d;
        end
    end

    // NOTE: the buffer is built from flops rather than a RAM macro because reset must refill it with spaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < MSG_MAX; a++) begin
                    bank_q[b][a] <= 6'(CHAR_SPACE);
                end
            end
        end else if (wr_fire) begin
            bank_q[~bank_sel_q][wr_addr] <= wr_char;
        end
    end

    assign wr_ready  = !pending_q;
    assign sel       = sel_q;
    assign segm      = segm_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_seg14_scroll_scan.sv
// Randomised and directed bench for seg14_scroll_scan against a slot/frame-level reference model.
module tb_seg14_scroll_scan;

    localparam int CLK_DIV       = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int FRAME_CYC     = 12 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = '0;
    logic [5:0]  wr_char = '0;
    logic        commit = 1'b0;
    logic [4:0]  commit_len = '0;
    logic        scroll_en = 1'b0;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        frame_end;

    seg14_scroll_scan #(
        .CLK_DIV       (CLK_DIV),
        .SCROLL_FRAMES (SCROLL_FRAMES),
        .MSG_MAX       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .commit     (commit),
        .commit_len (commit_len),
        .scroll_en  (scroll_en),
        .sel        (sel),
        .segm       (segm),
        .frame_end  (frame_end)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Character table as the display is expected to render it.
    function automatic logic [13:0] ref_font(input int code);
        case (code)
            0:  return 14'b11111100001001;
            1:  return 14'b01100000001000;
            2:  return 14'b11011011000000;
            3:  return 14'b11110001000000;
            4:  return 14'b01100111000000;
            5:  return 14'b10110111000000;
            6:  return 14'b10111111000000;
            7:  return 14'b11100000000000;
            8:  return 14'b11111111000000;
            9:  return 14'b11110111000000;
            10: return 14'b11101111000000;
            11: return 14'b11110001010010;
            12: return 14'b10011100000000;
            13: return 14'b11110000010010;
            14: return 14'b10011110000000;
            15: return 14'b10001110000000;
            16: return 14'b10111101000000;
            17: return 14'b01101111000000;
            18: return 14'b10010000010010;
            19: return 14'b01111000000000;
            20: return 14'b00001110001100;
            21: return 14'b00011100000000;
            22: return 14'b01101100101000;
            23: return 14'b01101100100100;
            24: return 14'b11111100000000;
            25: return 14'b11001111000000;
            26: return 14'b11111100000100;
            27: return 14'b11001111000100;
            28: return 14'b10110111000000;
            29: return 14'b10000000010010;
            30: return 14'b01111100000000;
            31: return 14'b00001100001001;
            32: return 14'b01101100000101;
            33: return 14'b00000000101101;
            34: return 14'b00000000101010;
            35: return 14'b10010000001001;
            default: return 14'b0;
        endcase
    endfunction

    // Reference model: message arrays plus slot/frame bookkeeping.
    int          m_edges, m_slot;
    int          m_shadow [16];
    int          m_active [16];
    int          m_len, m_len_pend, m_offset, m_fcnt;
    bit          m_pending;
    logic [11:0] e_sel;
    logic [13:0] e_segm;
    bit          e_fe;

    task automatic model_reset();
        m_edges = 0; m_slot = 0;
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = 36;
            m_active[i] = 36;
        end
        m_len = 0; m_len_pend = 0; m_offset = 0; m_fcnt = 0; m_pending = 0;
        e_sel = '0; e_segm = '0; e_fe = 0;
    endtask

    function automatic logic [13:0] ref_digit(input int p, input bit scr);
        if (scr) return ref_font(m_active[(m_offset + p) % m_len]);
        if (p >= m_len) return 14'b0;
        return ref_font(m_active[p]);
    endfunction

    task automatic model_edge();
        bit pend0, scr;
        int p, tmp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_edges++;
        pend0 = m_pending;
        e_fe = 0;
        if (m_edges % CLK_DIV == 0) begin
            p = m_slot % 12;
            scr = scroll_en && (m_len > 12);
            e_sel = 12'(1) << p;
            e_segm = ref_digit(p, scr);
            if (p == 11) begin
                e_fe = 1;
                if (pend0) begin
                    for (int i = 0; i < 16; i++) begin
                        tmp = m_active[i];
                        m_active[i] = m_shadow[i];
                        m_shadow[i] = tmp;
                    end
                    m_len = m_len_pend; m_offset = 0; m_fcnt = 0; m_pending = 0;
                end else if (scr) begin
                    if (m_fcnt == SCROLL_FRAMES - 1) begin
                        m_fcnt = 0;
                        m_offset = (m_offset + 1) % m_len;
                    end else begin
                        m_fcnt++;
                    end
                end else begin
                    m_offset = 0; m_fcnt = 0;
                end
            end
            m_slot++;
        end
        if (!pend0 && wr_valid) m_shadow[wr_addr] = int'(wr_char);
        if (!pend0 && commit) begin
            m_pending = 1;
            m_len_pend = (commit_len > 16) ? 16 : int'(commit_len);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sel", sel, e_sel);
        check("segm", segm, e_segm);
        check("frame_end", frame_end, e_fe);
        check("wr_ready", wr_ready, !m_pending);
    endtask

    task automatic write_char(input int addr, input int ch);
        wr_valid = 1; wr_addr = 4'(addr); wr_char = 6'(ch);
        step();
        wr_valid = 0;
    endtask

    task automatic do_commit(input int len);
        commit = 1; commit_len = 5'(len);
        step();
        commit = 0;
    endtask

    task automatic run_to_swap();
        for (int i = 0; i < 4 * FRAME_CYC && m_pending; i++) step();
    endtask

    task automatic check_reset_outputs();
        check("rst_sel", sel, 12'h000);
        check("rst_segm", segm, 14'h0000);
        check("rst_frame_end", frame_end, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int daniel_codes [9];
        logic [13:0] daniel_segs [12];
        int msg [16];
        int fe_count;

        daniel_codes = '{13, 10, 23, 18, 14, 21, 36, 28, 1};
        daniel_segs = '{14'b11110000010010, 14'b11101111000000, 14'b01101100100100,
                        14'b10010000010010, 14'b10011110000000, 14'b00011100000000,
                        14'b00000000000000, 14'b10110111000000, 14'b01100000001000,
                        14'b0, 14'b0, 14'b0};

        // Reset state and free-running blank scan.
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1;
        fe_count = 0;
        for (int i = 1; i <= 2 * FRAME_CYC; i++) begin
            step();
            if (frame_end) fe_count++;
            if (i == CLK_DIV - 1) check("pre_first_sel", sel, 12'h000);
            if (i == CLK_DIV) check("first_sel", sel, 12'h001);
            if (i == FRAME_CYC) check("first_frame_end", frame_end, 1'b1);
        end
        check("frame_end_count", fe_count, 2);

        // Static message, last write in the same cycle as commit.
        for (int i = 0; i < 8; i++) write_char(i, daniel_codes[i]);
        wr_valid = 1; wr_addr = 4'd8; wr_char = 6'(daniel_codes[8]);
        do_commit(9);
        wr_valid = 0;
        run_to_swap();
        for (int k = 0; k < 12; k++) begin
            repeat (CLK_DIV) step();
            check("daniel_sel", sel, 12'(1) << k);
            check("daniel_segm", segm, daniel_segs[k]);
        end

        // Writes while a commit is pending are refused.
        do_commit(9);
        wr_valid = 1; wr_addr = 4'd0; wr_char = 6'd33;
        for (int i = 0; i < 4 * FRAME_CYC && m_pending; i++) step();
        wr_valid = 0;
        repeat (CLK_DIV) step();
        check("blocked_write", segm, 14'b0);
        do_commit(9);
        run_to_swap();
        repeat (CLK_DIV) step();
        check("shadow_kept", segm, daniel_segs[0]);

        // 14-character scroll.
        scroll_en = 1;
        for (int i = 0; i < 16; i++) begin
            msg[i] = $urandom_range(0, 36);
            write_char(i, msg[i]);
        end
        do_commit(14);
        run_to_swap();
        for (int f = 0; f < 30; f++) begin
            repeat (CLK_DIV) step();
            if (f == 0 || f == 2 || f == 26 || f == 28)
                check("scroll_digit0", segm, ref_font(msg[(f / 2) % 14]));
            repeat (11 * CLK_DIV) step();
            if (f == 28) check("scroll_wrap_digit11", segm, ref_font(msg[11]));
        end

        // Clamped length, second commit while pending ignored.
        for (int i = 0; i < 16; i++) begin
            msg[i] = $urandom_range(0, 36);
            write_char(i, msg[i]);
        end
        do_commit(20);
        do_commit(5);
        run_to_swap();
        for (int f = 0; f <= 8; f++) begin
            for (int k = 0; k < 12; k++) begin
                repeat (CLK_DIV) step();
                if (f == 0) check("clamp_digit", segm, ref_font(msg[k]));
                if (f == 8 && k == 11) check("clamp_scroll_end", segm, ref_font(msg[15]));
            end
        end

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_char = 6'($urandom_range(0, 63));
            commit = ($urandom_range(0, 39) == 0);
            commit_len = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) scroll_en = ~scroll_en;
            step();
        end
        wr_valid = 0; commit = 0;

        // Asynchronous reset mid-frame with a commit pending.
        scroll_en = 0;
        run_to_swap();
        do_commit(10);
        repeat (5) step();
        check("pending_before_rst", wr_ready, 1'b0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1;
        repeat (2 * FRAME_CYC) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
